// File: rtl/lpf_pkg.sv
// Shared definitions for the one-pole low-pass filter blocks: default
// coefficient format, saturation limits and the scheduler FSM encoding.
package lpf_pkg;

  localparam int SCALE_DEF   = 15;
  localparam int ALPHA_Q_DEF = 12629;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    OUT
  } state_t;

  // Largest value representable in a signed word of the given width.
  function automatic int sat_max(input int width);
    return (1 <<< (width - 1)) - 1;
  endfunction

  // Smallest value representable in a signed word of the given width.
  function automatic int sat_min(input int width);
    return -(1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/lpf_step.sv
// One stateless step of a one-pole low-pass filter:
//   y = sat(y_prev + round(alpha * (x - y_prev)))
// alpha is ALPHA_Q / 2^SCALE. Rounding is half-up (toward +inf).
module lpf_step
  import lpf_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int SCALE   = SCALE_DEF,
  parameter int ALPHA_Q = ALPHA_Q_DEF
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y_prev,
  output logic signed [WIDTH-1:0] y
);

  // Wide enough for the full product of a (WIDTH+1)-bit difference and a
  // positive SCALE-bit coefficient, plus a sign bit of headroom for rounding.
  localparam int PW = WIDTH + SCALE + 2;

  localparam logic signed [PW-1:0] ALPHA_EXT = PW'(ALPHA_Q);
  localparam logic signed [PW-1:0] HALF      = PW'(1) << (SCALE - 1);
  localparam logic signed [PW-1:0] Y_MAX     = PW'(sat_max(WIDTH));
  localparam logic signed [PW-1:0] Y_MIN     = PW'(sat_min(WIDTH));

  logic signed [WIDTH:0]  diff;
  logic signed [PW-1:0]   diff_ext;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   scaled;
  logic signed [PW-1:0]   acc;

  // Difference, scale, round, accumulate and clamp in one combinational pass.
  always_comb begin
    diff     = {x[WIDTH-1], x} - {y_prev[WIDTH-1], y_prev};
    diff_ext = {{(PW - WIDTH - 1){diff[WIDTH]}}, diff};
    prod     = diff_ext * ALPHA_EXT;
    // Arithmetic shift floors, so adding half first gives round-half-up.
    scaled   = (prod + HALF) >>> SCALE;
    acc      = scaled + $signed({{(PW - WIDTH){y_prev[WIDTH-1]}}, y_prev});
    if (acc > Y_MAX) begin
      y = Y_MAX[WIDTH-1:0];
    end else if (acc < Y_MIN) begin
      y = Y_MIN[WIDTH-1:0];
    end else begin
      y = acc[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/lpf_chan_scheduler.sv
// Time-multiplexes one lpf_step datapath across N_CH sample channels.
// A round-robin arbiter accepts one sample at a time; the channel's stored
// output is fetched, updated, written back and emitted tagged with its id.
module lpf_chan_scheduler
  import lpf_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 10,
  parameter int SCALE   = SCALE_DEF,
  parameter int ALPHA_Q = ALPHA_Q_DEF,
  parameter int CHW     = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  output logic [N_CH-1:0]         in_ready,
  input  logic [N_CH-1:0]         clr,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CHW-1:0]          out_chan,
  input  logic                    out_ready,
  output logic                    busy
);

  state_t                   state;
  logic [CHW-1:0]           rr_ptr;
  logic [CHW-1:0]           cur_chan;
  logic signed [WIDTH-1:0]  x_reg;
  logic signed [WIDTH-1:0]  yprev_reg;
  logic signed [WIDTH-1:0]  step_y;
  logic                     kill;
  logic signed [WIDTH-1:0]  y_state [N_CH];

  logic                     grant_valid;
  logic [CHW-1:0]           grant_idx;
  int                       cand;

  lpf_step #(
    .WIDTH   (WIDTH),
    .SCALE   (SCALE),
    .ALPHA_Q (ALPHA_Q)
  ) u_step (
    .x      (x_reg),
    .y_prev (yprev_reg),
    .y      (step_y)
  );

  // Round-robin search: first requesting channel at or after rr_ptr.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < N_CH; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_CH) cand = cand - N_CH;
      if (!grant_valid && in_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = CHW'(cand);
      end
    end
  end

  // Accept strobe goes to the granted channel only while idle and out of reset.
  always_comb begin
    in_ready = '0;
    if (rst_n && state == IDLE && grant_valid) in_ready[grant_idx] = 1'b1;
  end

  assign busy = (state != IDLE);

  // Scheduler FSM: accept, compute, hold the result until downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_chan  <= '0;
      x_reg     <= '0;
      yprev_reg <= '0;
      kill      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cur_chan  <= grant_idx;
            x_reg     <= in_data[grant_idx*WIDTH +: WIDTH];
            yprev_reg <= y_state[grant_idx];
            rr_ptr    <= (grant_idx == CHW'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
            // A clear in the accept cycle already invalidates the writeback.
            kill      <= clr[grant_idx];
            state     <= CALC;
          end
        end
        CALC: begin
          if (clr[cur_chan]) kill <= 1'b1;
          out_data  <= step_y;
          out_chan  <= cur_chan;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            kill      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-channel filter state: clear has priority over the CALC writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this state array is a handful of flops that must read zero after reset, so it is reset explicitly rather than inferred as RAM.
      for (int k = 0; k < N_CH; k++) y_state[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (clr[k]) begin
          y_state[k] <= '0;
        end else if (state == CALC && !kill && cur_chan == CHW'(k)) begin
          y_state[k] <= step_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_lpf_chan_scheduler.sv
// Directed bench for lpf_chan_scheduler with a scoreboard of expected outputs.
module tb_lpf_chan_scheduler;

  localparam int N_CH  = 4;
  localparam int WIDTH = 10;
  localparam int CHW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_ready;
  logic [N_CH-1:0]       clr;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [CHW-1:0]        out_chan;
  logic                  out_ready;
  logic                  busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ymodel [N_CH];

  typedef struct {
    int chan;
    int data;
    int acc_cyc;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  lpf_chan_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .clr       (clr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference filter step using floor division on the rounded product.
  function automatic int model_step(input int x, input int y);
    int num;
    int q;
    int r;
    num = (x - y) * 12629 + 16384;
    q   = num / 32768;
    if (num < 0 && q * 32768 != num) q = q - 1;
    r = y + q;
    if (r > 511) r = 511;
    if (r < -512) r = -512;
    return r;
  endfunction

  // Request channel ch with sample x, wait for its grant, push the expected result.
  task automatic accept(input int ch, input int x, input bit drop);
    int   g;
    exp_t e;
    in_data[ch*WIDTH +: WIDTH] = x[WIDTH-1:0];
    in_valid[ch] = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready != '0) break;
      @(negedge clk);
    end
    check("grant_seen", int'(in_ready != '0), 1);
    check("grant_onehot", int'($onehot(in_ready)), 1);
    g = -1;
    for (int k = 0; k < N_CH; k++) if (in_ready[k]) g = k;
    check("grant_chan", g, ch);
    e.chan    = ch;
    e.data    = model_step(x, ymodel[ch]);
    e.acc_cyc = cyc;
    ymodel[ch] = e.data;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check("ready_pulse", in_ready, 0);
    if (drop) in_valid[ch] = 1'b0;
  endtask

  // Wait for a result, compare against the scoreboard head, complete the handshake.
  task automatic collect(input bit check_lat);
    exp_t e;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    check("out_valid_seen", out_valid, 1);
    check("sb_nonempty", int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (check_lat) check("latency", cyc - e.acc_cyc, 2);
      check("out_data", $signed(out_data), e.data);
      check("out_chan", out_chan, e.chan);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("out_valid_drop", out_valid, 0);
  endtask

  task automatic do_reset(input logic [N_CH-1:0] valid_during);
    rst_n    = 1'b0;
    in_valid = valid_during;
    clr      = '0;
    out_ready = 1'b1;
    sb.delete();
    for (int k = 0; k < N_CH; k++) ymodel[k] = 0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", $signed(out_data), 0);
    check("rst_out_chan", out_chan, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int rr_data [N_CH];
    exp_t head;
    in_data = '0;
    do_reset('0);

    // Basic step response on ch0, then a negative step on a fresh ch1.
    accept(0, 100, 1'b1);
    collect(1'b1);
    accept(0, 100, 1'b1);
    collect(1'b0);
    accept(1, -512, 1'b1);
    collect(1'b0);
    // Driving ch0 with its own state value leaves it unchanged at 63.
    accept(0, 63, 1'b1);
    collect(1'b0);

    // Backpressure: hold OUT for 10 cycles with ch1 pending.
    out_ready = 1'b0;
    accept(3, 200, 1'b1);
    in_data[1*WIDTH +: WIDTH] = 10'sd5;
    in_valid[1] = 1'b1;
    @(negedge clk);
    head = sb[0];
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", $signed(out_data), head.data);
      check("bp_out_chan", out_chan, head.chan);
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
      @(negedge clk);
    end
    collect(1'b0);
    accept(1, 5, 1'b1);
    collect(1'b0);

    // Clear of the in-flight channel during CALC.
    accept(2, 100, 1'b1);
    collect(1'b0);
    accept(2, 100, 1'b1);
    collect(1'b0);
    accept(2, 100, 1'b1);
    clr[2] = 1'b1;
    @(negedge clk);
    clr[2] = 1'b0;
    ymodel[2] = 0;
    collect(1'b0);
    accept(2, 100, 1'b1);
    collect(1'b0);

    // Reset asserted while holding a result in OUT.
    out_ready = 1'b0;
    accept(0, 100, 1'b1);
    @(negedge clk);
    check("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_data", $signed(out_data), 0);
    sb.delete();
    for (int k = 0; k < N_CH; k++) ymodel[k] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    accept(0, 100, 1'b1);
    collect(1'b0);

    // Round-robin: all channels requesting continuously from reset.
    rr_data[0] = 40;
    rr_data[1] = -40;
    rr_data[2] = 300;
    rr_data[3] = -300;
    for (int k = 0; k < N_CH; k++) in_data[k*WIDTH +: WIDTH] = rr_data[k][WIDTH-1:0];
    do_reset('1);
    for (int i = 0; i < 5; i++) begin
      accept(i % N_CH, rr_data[i % N_CH], 1'b0);
      collect(1'b0);
    end
    in_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lpf_chan_scheduler.md
Name: lpf_chan_scheduler

Overview:
- Time-multiplexes one stateless one-pole low-pass datapath, y = y_prev + round(alpha*(x - y_prev)), across N independent sample channels.
- Round-robin arbitration picks a requesting channel. The block fetches that channel's stored y_prev, computes and saturates the result, writes it back to per-channel state, and emits it tagged with the channel id.
- Sits between per-channel ADC/decimator sample streams and the downstream control loop.

Parameters:
- N_CH, 4, number of channels (2..16).
- WIDTH, 10, signed sample width of inputs, outputs and state.
- SCALE, 15, fractional bits of ALPHA_Q.
- ALPHA_Q, 12629, alpha in Q(SCALE); must satisfy 0 < ALPHA_Q < 2^SCALE.
- CHW, $clog2(N_CH), channel-id width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  N_CH  per-channel sample request.
- in_data  in  N_CH*WIDTH  packed signed samples; channel k occupies [k*WIDTH +: WIDTH].
- in_ready  out  N_CH  one-hot accept strobe.
- clr  in  N_CH  per-channel state clear (y_prev := 0).
- out_valid  out  1  result valid.
- out_data  out  WIDTH  signed filtered sample.
- out_chan  out  CHW  channel id of out_data.
- out_ready  in  1  downstream accept.
- busy  out  1  high when FSM != IDLE.

Behaviour:
- Reset (async): FSM=IDLE, all y_state=0, rr_ptr=0, kill=0, in_ready=0, out_valid=0, out_data=0, out_chan=0.
- FSM IDLE:
  - If any in_valid, grant the first requesting channel at or after rr_ptr, wrapping modulo N_CH.
  - Drive in_ready[g]=1 combinationally in that cycle (the handshake completes there).
  - Latch g, in_data[g] and y_state[g]; set rr_ptr=(g+1) mod N_CH; go CALC.
  - No request: stay IDLE; in_ready=0.
- FSM CALC, one cycle; register the result:
  - diff = x - y_prev (WIDTH+1 bits).
  - prod = diff*ALPHA_Q (signed, WIDTH+SCALE+2 bits).
  - scaled = (prod + 2^(SCALE-1)) >>> SCALE, arithmetic shift (round-half-up toward +inf).
  - acc = y_prev + scaled.
  - Saturate acc to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Write y_state[g]=result unless kill is set or clr[g] is asserted this cycle. Go OUT.
- FSM OUT:
  - out_valid=1 with out_data and out_chan stable until out_valid&&out_ready; then go IDLE.
- Latency: accept cycle T, out_valid at T+2. Peak throughput: one sample per 3 cycles.
- in_ready=0 in CALC and OUT. No accept while a sample is in flight (single-entry pipeline).
- Backpressure: out_ready low holds OUT indefinitely. Other channels' in_valid stay pending and are not dropped.
- clr[k] in any state clears y_state[k] to 0 on the next edge.
- If clr[g] (the in-flight channel) is asserted in any cycle from accept through CALC, set sticky kill. The CALC writeback is suppressed, so the cleared state wins. out_data still carries the computed value. kill is cleared on entering IDLE.
- clr on a non-granted channel never disturbs the in-flight transaction.
- A deasserted in_valid on a non-granted channel is legal; the arbiter only samples in IDLE.
- Reset asserted mid-transaction aborts immediately to the reset values; no output is produced.

Decomposition:
- Package lpf_pkg: ALPHA_Q and SCALE defaults, functions sat_max(WIDTH)/sat_min(WIDTH), FSM state enum {IDLE, CALC, OUT}.
- Sub-module lpf_step: purely combinational (x, y_prev) -> saturated y, parameterised WIDTH/SCALE/ALPHA_Q; reusable by other filter blocks.
- Scheduler top holds the FSM, round-robin arbiter, y_state array and kill flag.

Test Plan:
- After reset, ch0 x=100 with out_ready=1 -> in_ready[0] at T, out_valid at T+2, out_data=39, out_chan=0. Second x=100 on ch0 -> out_data=63.
- ch1 fresh, x=-512 -> out_data=-197 (checks arithmetic shift and rounding on negatives); ch0 state stays 63.
- All four in_valid held high from reset -> grant order 0,1,2,3,0; each in_ready is a single-cycle one-hot pulse; no channel is starved.
- out_ready held low 10 cycles while in OUT -> out_valid/out_data/out_chan stable, in_ready=0 throughout; one transfer occurs when out_ready rises.
- ch2 state 63, new x=100 accepted, clr[2] pulsed in CALC -> output 77, y_state[2]=0; next x=100 on ch2 -> 39.
- Assert rst_n low while in OUT -> out_valid=0 immediately, all state 0; ch0 x=100 then -> 39.
